id_digit_scanner: RTL and testbench
===================================

// Module: id_digit_scanner
// PURPOSE
//  Parametrised, sequential successor to the ALU3 student-ID compare unit. Holds a
//  writable NUM_DIGITS-digit ID register and compares every nibble of operand a
//  against it: one selected digit (single mode) or all digits in turn (scan mode).
//  Exposes a start/busy/done handshake. Sits beside the other ALU units and is
//  driven by the same one-hot op decoder.
// PARAMETERS
//  DATA_W      8   operand width; multiple of 4; a holds DATA_W/4 nibbles
//  NUM_DIGITS  9   stored ID digits, 1..15; opcode one-hot bits 0..NUM_DIGITS-1
//  CNT_W       $clog2(NUM_DIGITS+1)  width of match_count (derived, localparam)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  start        in   1           request; sampled only in IDLE
//  a            in   DATA_W      operand, latched on accepted start
//  op_dec       in   16          one-hot opcode, latched on accepted start
//  id_wr_en     in   1           write one ID digit
//  id_wr_idx    in   4           digit index to write
//  id_wr_digit  in   4           digit value
//  busy         out  1           high in SCAN and DONE
//  done         out  1           one-cycle pulse, results valid
//  ans          out  4           4'b0001 if any match, else 4'b0000
//  match_count  out  CNT_W       number of matching digits (scan), 0/1 (single)
//  err          out  1           illegal opcode on last operation
//  match_mask   out  NUM_DIGITS  per-digit match flags (ID_MATCH_MASK_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM->IDLE; busy, done, err = 0; ans, match_count,
//    match_mask = 0; all ID digits = 4'h0. Applies immediately, incl. mid-scan.
//  - Digit k matches when id[k] equals any nibble of latched a.
//  - Opcode decode (latched copy): exactly one bit k set, k<NUM_DIGITS -> single
//    digit k; 16'h8000 -> scan all; anything else (zero, multi-hot, k>=NUM_DIGITS
//    other than bit 15) -> illegal.
//  - FSM IDLE -> SCAN on start (latch a, op_dec, clear accumulators).
//    SCAN: single/illegal = 1 cycle; scan = NUM_DIGITS cycles, digit index 0..N-1,
//    one digit per cycle, count accumulates. SCAN -> DONE after last cycle.
//    DONE: done=1 for exactly one cycle, then IDLE.
//  - Latency: start at edge T -> done high in the cycle after edge T+2 (single or
//    illegal) or T+NUM_DIGITS+1 (scan). busy high from T+1 until done drops.
//  - ans, match_count, err, match_mask update on SCAN->DONE edge; held until
//    the next accepted start clears them. Illegal: err=1, ans=0, count=0.
//  - start while busy: ignored, no queueing. start held high in DONE: not
//    accepted until IDLE (next cycle).
//  - id_wr_en: accepted only in IDLE; dropped while busy. id_wr_idx>=NUM_DIGITS
//    dropped. Same-edge id write + start in IDLE: write lands first, scan
//    uses the new digit.
//  - match_count saturates never (max NUM_DIGITS fits CNT_W); no wrap.
// CONFIGURATION
//  ID_MATCH_MASK_EN defined: match_mask port present, bit k = digit k matched
//    (single mode: only bit k can be set; illegal: all 0).
//  Undefined: match_mask port and its register absent; all else identical.
// TESTING (ID digits 0..8 loaded as 2,0,1,9,4,7,3,8,5 via id_wr)
//  1 single hit: op_dec=16'h0001, a=8'h52 -> done at T+3, ans=1, count=1, err=0
//  2 single miss: op_dec=16'h0008, a=8'h12 -> ans=0, count=0, err=0
//  3 scan: op_dec=16'h8000, a=8'h70 -> done at T+NUM_DIGITS+2, ans=1, count=2,
//    match_mask=9'b000100010 (with ID_MATCH_MASK_EN)
//  4 illegal: op_dec=16'h0003, then 16'h0200 -> err=1, ans=0, count=0, done T+3
//  5 rst_n=0 in 4th scan cycle -> busy/done/outputs 0 at once, ID reads all 0,
//    next scan a=8'h00 gives count=9
//  6 start and id_wr_en pulsed while busy -> no extra done, ID unchanged

Source files
------------

// File: rtl/id_digit_scanner.sv
// id_digit_scanner
// Sequential student-ID digit compare unit. Holds a writable NUM_DIGITS-digit
// ID register and compares the nibbles of operand a against one selected
// digit (single mode) or against every digit in turn (scan mode), with a
// start/busy/done handshake. Driven by the same one-hot op decoder as the
// other ALU units.
//
// Optional feature macro: ID_MATCH_MASK_EN (adds the match_mask port).
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   operation request, sampled only in IDLE
//   a            in   operand, DATA_W/4 nibbles, latched on accepted start
//   op_dec       in   one-hot opcode (bit k: digit k, bit 15: scan all)
//   id_wr_en     in   write one ID digit (IDLE only)
//   id_wr_idx    in   digit index to write (>= NUM_DIGITS is dropped)
//   id_wr_digit  in   digit value
//   busy         out  high while scanning and during the done cycle
//   done         out  one-cycle pulse, results valid
//   ans          out  4'b0001 if any digit matched
//   match_count  out  number of matching digits
//   err          out  last opcode was illegal
//   match_mask   out  per-digit match flags (ID_MATCH_MASK_EN only)
//
// state | meaning
// IDLE  | waiting for start; ID writes accepted here
// ARM   | operand/opcode latched, opcode decoded from the latched copy
// SCAN  | one digit compared per cycle (one cycle for single/illegal)
// DONE  | results valid, done pulse
module id_digit_scanner #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 9,
    localparam int CNT_W     = $clog2(NUM_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [15:0]           op_dec,
    input  logic                  id_wr_en,
    input  logic [3:0]            id_wr_idx,
    input  logic [3:0]            id_wr_digit,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            ans,
    output logic [CNT_W-1:0]      match_count,
    output logic                  err
`ifdef ID_MATCH_MASK_EN
    ,
    output logic [NUM_DIGITS-1:0] match_mask
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);
    localparam logic [4:0] NUM_D5   = 5'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [3:0]          id_mem [NUM_DIGITS];
    logic [DATA_W-1:0]   a_lat;
    logic [15:0]         op_lat;
    logic [3:0]          idx;
    logic [CNT_W-1:0]    acc_cnt;

    logic                is_scan;
    logic                is_single;
    logic [3:0]          sel_idx;
    logic [3:0]          cmp_idx;
    logic [3:0]          cur_digit;
    logic                hit;
    logic [CNT_W-1:0]    scan_total;

`ifdef ID_MATCH_MASK_EN
    logic [NUM_DIGITS-1:0] acc_mask;
    logic [NUM_DIGITS-1:0] mask_next;
`endif

    // Bit 15 alone means scan; a single bit below NUM_DIGITS selects that digit.
    always_comb begin
        sel_idx = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (op_lat[k]) sel_idx = 4'(k);
        end
    end

    assign is_scan   = (op_lat == 16'h8000);
    assign is_single = $onehot(op_lat) && (|op_lat[NUM_DIGITS-1:0]);
    assign cmp_idx   = is_scan ? idx : sel_idx;
    assign cur_digit = id_mem[cmp_idx];

    always_comb begin
        hit = 1'b0;
        for (int n = 0; n < DATA_W / 4; n++) begin
            if (a_lat[n*4 +: 4] == cur_digit) hit = 1'b1;
        end
    end

    assign scan_total = acc_cnt + CNT_W'(hit);

`ifdef ID_MATCH_MASK_EN
    assign mask_next = acc_mask | (NUM_DIGITS'(hit) << cmp_idx);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ans         <= 4'd0;
            match_count <= '0;
            a_lat       <= '0;
            op_lat      <= '0;
            idx         <= 4'd0;
            acc_cnt     <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) id_mem[k] <= 4'h0;
`ifdef ID_MATCH_MASK_EN
            acc_mask    <= '0;
            match_mask  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A write on the same edge as start lands before the compare.
                    if (id_wr_en && ({1'b0, id_wr_idx} < NUM_D5))
                        id_mem[id_wr_idx] <= id_wr_digit;
                    if (start) begin
                        a_lat       <= a;
                        op_lat      <= op_dec;
                        idx         <= 4'd0;
                        acc_cnt     <= '0;
                        ans         <= 4'd0;
                        match_count <= '0;
                        err         <= 1'b0;
`ifdef ID_MATCH_MASK_EN
                        acc_mask    <= '0;
                        match_mask  <= '0;
`endif
                        state       <= ARM;
                    end
                end
                ARM: begin
                    busy  <= 1'b1;
                    state <= SCAN;
                end
                SCAN: begin
                    if (is_scan) begin
                        acc_cnt  <= scan_total;
`ifdef ID_MATCH_MASK_EN
                        acc_mask <= mask_next;
`endif
                        if (idx == LAST_IDX) begin
                            ans         <= {3'b000, scan_total != '0};
                            match_count <= scan_total;
`ifdef ID_MATCH_MASK_EN
                            match_mask  <= mask_next;
`endif
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        if (is_single) begin
                            ans         <= {3'b000, hit};
                            match_count <= CNT_W'(hit);
`ifdef ID_MATCH_MASK_EN
                            match_mask  <= mask_next;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_digit_scanner.sv
module tb_id_digit_scanner;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [15:0] op_dec = 16'h0000;
    logic        id_wr_en = 1'b0;
    logic [3:0]  id_wr_idx = 4'd0;
    logic [3:0]  id_wr_digit = 4'd0;
    logic        busy, done, err;
    logic [3:0]  ans;
    logic [3:0]  match_count;
`ifdef ID_MATCH_MASK_EN
    logic [N-1:0] match_mask;
`endif

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    id_digit_scanner #(.DATA_W(8), .NUM_DIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .op_dec(op_dec),
        .id_wr_en(id_wr_en), .id_wr_idx(id_wr_idx), .id_wr_digit(id_wr_digit),
        .busy(busy), .done(done), .ans(ans), .match_count(match_count), .err(err)
`ifdef ID_MATCH_MASK_EN
        , .match_mask(match_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_id [N] = '{default: 0};
    int m_phase = 0;       // 0 = idle, else cycles since accepted start
    int m_len = 1;         // compare cycles of the running operation
    int e_ans = 0, e_cnt = 0, e_err = 0, e_mask = 0;
    int p_ans = 0, p_cnt = 0, p_err = 0, p_mask = 0;

    function automatic bit digit_hit(input int d, input logic [7:0] av);
        return (d == int'(av[3:0])) || (d == int'(av[7:4]));
    endfunction

    task automatic calc(input logic [7:0] av, input logic [15:0] op,
                        output int r_ans, output int r_cnt, output int r_err, output int r_mask);
        int pos;
        r_ans = 0; r_cnt = 0; r_err = 0; r_mask = 0;
        pos = -1;
        for (int k = 0; k < 16; k++) if (op == (16'h1 << k)) pos = k;
        if (pos == 15) begin
            for (int k = 0; k < N; k++)
                if (digit_hit(m_id[k], av)) begin r_cnt++; r_mask += (1 << k); end
        end else if (pos >= 0 && pos < N) begin
            if (digit_hit(m_id[pos], av)) begin r_cnt = 1; r_mask = 1 << pos; end
        end else begin
            r_err = 1;
        end
        r_ans = (r_cnt > 0) ? 1 : 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_id[k] = 0;
            m_phase = 0;
            e_ans = 0; e_cnt = 0; e_err = 0; e_mask = 0;
        end else if (m_phase == 0) begin
            if (id_wr_en && id_wr_idx < N) m_id[id_wr_idx] = int'(id_wr_digit);
            if (start) begin
                calc(a, op_dec, p_ans, p_cnt, p_err, p_mask);
                m_len = (op_dec == 16'h8000) ? N : 1;
                e_ans = 0; e_cnt = 0; e_err = 0; e_mask = 0;
                m_phase = 1;
            end
        end else if (m_phase == m_len + 2) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == m_len + 2) begin
                e_ans = p_ans; e_cnt = p_cnt; e_err = p_err; e_mask = p_mask;
            end
        end
    end

    // Single compare process: every cycle, DUT vs model.
    always @(negedge clk) begin
        chk("busy", int'(busy), (m_phase >= 2) ? 1 : 0);
        chk("done", int'(done), (m_phase != 0 && m_phase == m_len + 2) ? 1 : 0);
        chk("ans", int'(ans), e_ans);
        chk("match_count", int'(match_count), e_cnt);
        chk("err", int'(err), e_err);
`ifdef ID_MATCH_MASK_EN
        chk("match_mask", int'(match_mask), e_mask);
`endif
        if (done) done_seen++;
    end

    // ---------------- directed stimulus ----------------
    task automatic wr_id(input int idx, input int dig);
        id_wr_en = 1'b1; id_wr_idx = 4'(idx); id_wr_digit = 4'(dig);
        @(negedge clk);
        id_wr_en = 1'b0;
    endtask

    // Called at a negedge; returns negedges from the accept edge until done.
    task automatic run_op(input logic [7:0] av, input logic [15:0] op, output int cyc);
        a = av; op_dec = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    int cyc, t0, t1, ds, budget;
    int ids [N] = '{2, 0, 1, 9, 4, 7, 3, 8, 5};

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) wr_id(k, ids[k]);

        // 1 single hit
        run_op(8'h52, 16'h0001, cyc);
        chk("t1_latency", cyc, 2);
        chk("t1_ans", int'(ans), 1);
        chk("t1_count", int'(match_count), 1);
        chk("t1_err", int'(err), 0);
        settle();

        // 2 single miss
        run_op(8'h12, 16'h0008, cyc);
        chk("t2_ans", int'(ans), 0);
        chk("t2_count", int'(match_count), 0);
        settle();

        // 3 full scan
        run_op(8'h70, 16'h8000, cyc);
        chk("t3_latency", cyc, N + 1);
        chk("t3_ans", int'(ans), 1);
        chk("t3_count", int'(match_count), 2);
`ifdef ID_MATCH_MASK_EN
        chk("t3_mask", int'(match_mask), 9'b000100010);
`endif
        settle();

        // 4 illegal opcodes
        run_op(8'h52, 16'h0003, cyc);
        chk("t4a_latency", cyc, 2);
        chk("t4a_err", int'(err), 1);
        chk("t4a_ans", int'(ans), 0);
        settle();
        run_op(8'h52, 16'h0200, cyc);
        chk("t4b_err", int'(err), 1);
        chk("t4b_count", int'(match_count), 0);
        settle();
        run_op(8'h00, 16'h0000, cyc);
        chk("t4c_err", int'(err), 1);
        settle();

        // same-edge write and start: new digit 2 = 6 is used
        id_wr_en = 1'b1; id_wr_idx = 4'd2; id_wr_digit = 4'd6;
        a = 8'h06; op_dec = 16'h0004; start = 1'b1;
        @(negedge clk);
        id_wr_en = 1'b0; start = 1'b0;
        budget = 0;
        while (!done && budget < 40) begin @(negedge clk); budget++; end
        chk("wr_start_ans", int'(ans), 1);
        settle();

        // out-of-range write dropped; only digit 6 holds 3
        wr_id(9, 3);
        run_op(8'h33, 16'h8000, cyc);
        chk("oor_wr_count", int'(match_count), 1);
        settle();

        // start held high: next accept only after returning to IDLE
        a = 8'h52; op_dec = 16'h0001; start = 1'b1;
        t0 = -1; t1 = -1; budget = 0;
        while (t1 < 0 && budget < 40) begin
            @(negedge clk);
            budget++;
            if (done && t0 < 0) t0 = budget;
            else if (done && t0 >= 0) t1 = budget;
        end
        start = 1'b0;
        chk("held_start_gap", t1 - t0, 4);
        repeat (6) @(negedge clk);

        // 6 start and id write while busy are dropped
        ds = done_seen;
        a = 8'h70; op_dec = 16'h8000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; id_wr_en = 1'b1; id_wr_idx = 4'd0; id_wr_digit = 4'd7;
        @(negedge clk);
        start = 1'b0; id_wr_en = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_done_pulses", done_seen - ds, 1);
        run_op(8'h22, 16'h0001, cyc);
        chk("t6_id_unchanged", int'(ans), 1);
        settle();

        // 5 reset in the 4th scan cycle
        a = 8'h70; op_dec = 16'h8000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", int'(busy), 0);
        chk("t5_done_rst", int'(done), 0);
        chk("t5_count_rst", int'(match_count), 0);
        chk("t5_ans_rst", int'(ans), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h00, 16'h8000, cyc);
        chk("t5_zero_scan_count", int'(match_count), 9);
        chk("t5_zero_scan_ans", int'(ans), 1);
`ifdef ID_MATCH_MASK_EN
        chk("t5_zero_scan_mask", int'(match_mask), 9'h1FF);
`endif
        settle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
